// File: rtl/tl_pkg.sv
// Shared TileLink constants, fragmenter widths and the fragmenter FSM state type.
package tl_pkg;

    localparam int TL_RS = 4;   // source-ID width
    localparam int TL_AW = 16;  // byte-address width

    // Largest lg2 transfer size accepted (64 B = 16 beats of 4 B).
    localparam logic [3:0] MAX_SIZE = 4'd6;

    // A-channel opcodes
    localparam logic [2:0] OP_PUT_FULL    = 3'd0;
    localparam logic [2:0] OP_PUT_PARTIAL = 3'd1;
    localparam logic [2:0] OP_ARITH       = 3'd2;
    localparam logic [2:0] OP_LOGICAL     = 3'd3;
    localparam logic [2:0] OP_GET         = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] OP_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] OP_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [2:0] {
        IDLE,
        PASS,
        GET_ISSUE,
        PUT_FWD,
        DRAIN
    } frag_state_e;

    function automatic logic is_put(input logic [2:0] op);
        return (op == OP_PUT_FULL) || (op == OP_PUT_PARTIAL);
    endfunction

    function automatic logic is_atomic(input logic [2:0] op);
        return (op == OP_ARITH) || (op == OP_LOGICAL);
    endfunction

endpackage

// File: rtl/tl_beat_counter.sv
// Beat counter for a fragmented burst, plus the N = 2^(size-2) beat-count decode.
module tl_beat_counter
    import tl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear_i,
    input  logic       inc_i,
    input  logic [3:0] size_i,
    output logic [4:0] count_o,
    output logic [4:0] n_o
);

    logic [4:0] count_q, count_d;

    // Number of 4-byte beats for the latched burst size.
    always_comb begin
        // NOTE: assign a default before any condition so every path drives the output and no latch is inferred.
        n_o = 5'd1;
        if ((size_i > 4'd2) && (size_i <= MAX_SIZE)) begin
            n_o = 5'd1 << (size_i - 4'd2);
        end
    end

    // Next count: clear wins over increment.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + 5'd1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking <= so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/tl_fragmenter.sv
// TL-UH to single-beat TL-UL fragmenter: splits Get/Put bursts into 4-byte
// beats for a downstream SRAM slave and collapses the responses back.
module tl_fragmenter
    import tl_pkg::*;
(
    input  logic             frag_clock_i,
    input  logic             frag_reset_ni,

    input  logic [2:0]       up_a_opcode,
    input  logic [2:0]       up_a_param,
    input  logic [3:0]       up_a_size,
    input  logic [TL_RS-1:0] up_a_source,
    input  logic [TL_AW-1:0] up_a_address,
    input  logic [3:0]       up_a_mask,
    input  logic [31:0]      up_a_data,
    input  logic             up_a_corrupt,
    input  logic             up_a_valid,
    output logic             up_a_ready,

    output logic [2:0]       up_d_opcode,
    output logic [1:0]       up_d_param,
    output logic [3:0]       up_d_size,
    output logic [TL_RS-1:0] up_d_source,
    output logic             up_d_denied,
    output logic [31:0]      up_d_data,
    output logic             up_d_corrupt,
    output logic             up_d_valid,
    input  logic             up_d_ready,

    output logic [2:0]       dn_a_opcode,
    output logic [2:0]       dn_a_param,
    output logic [3:0]       dn_a_size,
    output logic [TL_RS-1:0] dn_a_source,
    output logic [TL_AW-1:0] dn_a_address,
    output logic [3:0]       dn_a_mask,
    output logic [31:0]      dn_a_data,
    output logic             dn_a_corrupt,
    output logic             dn_a_valid,
    input  logic             dn_a_ready,

    input  logic [2:0]       dn_d_opcode,
    input  logic [1:0]       dn_d_param,
    input  logic [3:0]       dn_d_size,
    input  logic [TL_RS-1:0] dn_d_source,
    input  logic             dn_d_denied,
    input  logic [31:0]      dn_d_data,
    input  logic             dn_d_corrupt,
    input  logic             dn_d_valid,
    output logic             dn_d_ready,

    output logic             proto_err_o
);

    frag_state_e      state_q, state_d;
    logic [TL_RS-1:0] src_q, src_d;
    logic [3:0]       size_q, size_d;
    logic [TL_AW-1:0] base_q, base_d;
    logic             is_put_q, is_put_d;
    logic             denied_q, denied_d;
    logic             proto_err_q, proto_err_d;

    logic             issue_inc, ack_inc, cnt_clear;
    logic [4:0]       issued_cnt, acked_cnt, issued_n, acked_n;
    logic             issue_last, ack_last, in_burst;
    logic [TL_AW-1:0] burst_addr;

    assign cnt_clear  = (state_q == IDLE);
    assign issue_last = (issued_cnt == (issued_n - 5'd1));
    assign ack_last   = (acked_cnt == (acked_n - 5'd1));
    assign in_burst   = (state_q == GET_ISSUE) || (state_q == PUT_FWD) || (state_q == DRAIN);
    // Modulo-2^TL_AW beat address; base low bits are already zero.
    assign burst_addr = base_q + {{(TL_AW-7){1'b0}}, issued_cnt, 2'b00};

    tl_beat_counter u_issued (
        .clk     (frag_clock_i),
        .rst_n   (frag_reset_ni),
        .clear_i (cnt_clear),
        .inc_i   (issue_inc),
        .size_i  (size_q),
        .count_o (issued_cnt),
        .n_o     (issued_n)
    );

    tl_beat_counter u_acked (
        .clk     (frag_clock_i),
        .rst_n   (frag_reset_ni),
        .clear_i (cnt_clear),
        .inc_i   (ack_inc),
        .size_i  (size_q),
        .count_o (acked_cnt),
        .n_o     (acked_n)
    );

    // Next-state, channel steering and handshake decode.
    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        size_d      = size_q;
        base_d      = base_q;
        is_put_d    = is_put_q;
        denied_d    = denied_q;
        proto_err_d = proto_err_q;
        issue_inc   = 1'b0;
        ack_inc     = 1'b0;

        up_a_ready   = 1'b0;
        dn_a_valid   = 1'b0;
        dn_a_opcode  = up_a_opcode;
        dn_a_param   = up_a_param;
        dn_a_size    = up_a_size;
        dn_a_source  = up_a_source;
        dn_a_address = up_a_address;
        dn_a_mask    = up_a_mask;
        dn_a_data    = up_a_data;
        dn_a_corrupt = up_a_corrupt;

        up_d_valid   = 1'b0;
        up_d_opcode  = dn_d_opcode;
        up_d_param   = dn_d_param;
        up_d_size    = dn_d_size;
        up_d_source  = dn_d_source;
        up_d_denied  = dn_d_denied;
        up_d_data    = dn_d_data;
        up_d_corrupt = dn_d_corrupt;
        dn_d_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                denied_d = 1'b0;
                if (up_a_valid) begin
                    if (up_a_size > MAX_SIZE) begin
                        // Oversized request: swallow it and flag the error.
                        up_a_ready  = 1'b1;
                        proto_err_d = 1'b1;
                    end else if (up_a_size <= 4'd2) begin
                        // Single-beat request of any opcode goes straight through.
                        dn_a_valid = 1'b1;
                        up_a_ready = dn_a_ready;
                        if (dn_a_ready) begin
                            state_d = PASS;
                        end
                    end else if (up_a_opcode == OP_GET) begin
                        up_a_ready = 1'b1;
                        src_d      = up_a_source;
                        size_d     = up_a_size;
                        base_d     = {up_a_address[TL_AW-1:2], 2'b00};
                        is_put_d   = 1'b0;
                        state_d    = GET_ISSUE;
                    end else if (is_put(up_a_opcode)) begin
                        // First Put beat stays on the bus and is forwarded from PUT_FWD.
                        src_d    = up_a_source;
                        size_d   = up_a_size;
                        base_d   = {up_a_address[TL_AW-1:2], 2'b00};
                        is_put_d = 1'b1;
                        state_d  = PUT_FWD;
                    end else begin
                        // Multi-beat atomics cannot be split into independent beats.
                        up_a_ready  = 1'b1;
                        proto_err_d = 1'b1;
                    end
                end
            end

            PASS: begin
                up_d_valid = dn_d_valid;
                dn_d_ready = up_d_ready;
                if (dn_d_valid && up_d_ready) begin
                    state_d = IDLE;
                end
            end

            GET_ISSUE: begin
                dn_a_valid   = 1'b1;
                dn_a_opcode  = OP_GET;
                dn_a_param   = 3'd0;
                dn_a_size    = 4'd2;
                dn_a_source  = src_q;
                dn_a_address = burst_addr;
                dn_a_mask    = 4'hF;
                dn_a_data    = 32'd0;
                dn_a_corrupt = 1'b0;
                issue_inc    = dn_a_ready;
                if (dn_a_ready && issue_last) begin
                    state_d = DRAIN;
                end
            end

            PUT_FWD: begin
                dn_a_valid   = up_a_valid;
                dn_a_size    = 4'd2;
                dn_a_source  = src_q;
                dn_a_address = burst_addr;
                up_a_ready   = dn_a_ready;
                issue_inc    = up_a_valid && dn_a_ready;
                if (issue_inc && issue_last) begin
                    state_d = DRAIN;
                end
            end

            DRAIN: begin
                dn_a_valid = 1'b0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // Burst responses are counted in every burst state, even while still issuing.
        if (in_burst) begin
            up_d_size   = size_q;
            up_d_source = src_q;
            if (!is_put_q) begin
                up_d_opcode = OP_ACCESS_ACK_DATA;
                up_d_valid  = dn_d_valid;
                dn_d_ready  = up_d_ready;
            end else if (!ack_last) begin
                // Intermediate Put acks are absorbed; remember any denial.
                dn_d_ready = 1'b1;
                if (dn_d_valid) begin
                    denied_d = denied_q | dn_d_denied;
                end
            end else begin
                up_d_opcode = OP_ACCESS_ACK;
                up_d_denied = dn_d_denied | denied_q;
                up_d_valid  = dn_d_valid;
                dn_d_ready  = up_d_ready;
            end
            ack_inc = dn_d_valid && dn_d_ready;
            if (ack_inc && ack_last) begin
                state_d = IDLE;
            end
        end

        // Handshake outputs stay low for as long as reset is held.
        if (!frag_reset_ni) begin
            up_a_ready = 1'b0;
            up_d_valid = 1'b0;
            dn_a_valid = 1'b0;
            dn_d_ready = 1'b0;
        end
    end

    // State, burst latches and sticky error flag.
    always_ff @(posedge frag_clock_i or negedge frag_reset_ni) begin
        if (!frag_reset_ni) begin
            state_q     <= IDLE;
            src_q       <= '0;
            size_q      <= '0;
            base_q      <= '0;
            is_put_q    <= 1'b0;
            denied_q    <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            size_q      <= size_d;
            base_q      <= base_d;
            is_put_q    <= is_put_d;
            denied_q    <= denied_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_tl_fragmenter.sv
// Directed bench for tl_fragmenter with a single-beat SRAM responder model.
module tb_tl_fragmenter;

    logic        clk;
    logic        rst_n;

    logic [2:0]  up_a_opcode, up_a_param;
    logic [3:0]  up_a_size;
    logic [3:0]  up_a_source;
    logic [15:0] up_a_address;
    logic [3:0]  up_a_mask;
    logic [31:0] up_a_data;
    logic        up_a_corrupt, up_a_valid, up_a_ready;

    logic [2:0]  up_d_opcode;
    logic [1:0]  up_d_param;
    logic [3:0]  up_d_size;
    logic [3:0]  up_d_source;
    logic        up_d_denied;
    logic [31:0] up_d_data;
    logic        up_d_corrupt, up_d_valid, up_d_ready;

    logic [2:0]  dn_a_opcode, dn_a_param;
    logic [3:0]  dn_a_size;
    logic [3:0]  dn_a_source;
    logic [15:0] dn_a_address;
    logic [3:0]  dn_a_mask;
    logic [31:0] dn_a_data;
    logic        dn_a_corrupt, dn_a_valid, dn_a_ready;

    logic [2:0]  dn_d_opcode;
    logic [1:0]  dn_d_param;
    logic [3:0]  dn_d_size;
    logic [3:0]  dn_d_source;
    logic        dn_d_denied;
    logic [31:0] dn_d_data;
    logic        dn_d_corrupt, dn_d_valid, dn_d_ready;

    logic        proto_err_o;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [3:0]  src;
        logic [15:0] addr;
        logic [3:0]  mask;
        logic [31:0] data;
    } a_beat_t;

    typedef struct packed {
        logic [2:0]  op;
        logic [3:0]  size;
        logic [3:0]  src;
        logic        denied;
        logic [31:0] data;
    } d_beat_t;

    a_beat_t pend[$];
    a_beat_t dn_log[$];
    d_beat_t up_log[$];
    a_beat_t head;

    bit          a_rand, d_rand, r_rand, deny_en;
    logic [15:0] deny_addr;
    int          n_cmp, n_bad;

    tl_fragmenter dut (
        .frag_clock_i  (clk),
        .frag_reset_ni (rst_n),
        .up_a_opcode   (up_a_opcode),
        .up_a_param    (up_a_param),
        .up_a_size     (up_a_size),
        .up_a_source   (up_a_source),
        .up_a_address  (up_a_address),
        .up_a_mask     (up_a_mask),
        .up_a_data     (up_a_data),
        .up_a_corrupt  (up_a_corrupt),
        .up_a_valid    (up_a_valid),
        .up_a_ready    (up_a_ready),
        .up_d_opcode   (up_d_opcode),
        .up_d_param    (up_d_param),
        .up_d_size     (up_d_size),
        .up_d_source   (up_d_source),
        .up_d_denied   (up_d_denied),
        .up_d_data     (up_d_data),
        .up_d_corrupt  (up_d_corrupt),
        .up_d_valid    (up_d_valid),
        .up_d_ready    (up_d_ready),
        .dn_a_opcode   (dn_a_opcode),
        .dn_a_param    (dn_a_param),
        .dn_a_size     (dn_a_size),
        .dn_a_source   (dn_a_source),
        .dn_a_address  (dn_a_address),
        .dn_a_mask     (dn_a_mask),
        .dn_a_data     (dn_a_data),
        .dn_a_corrupt  (dn_a_corrupt),
        .dn_a_valid    (dn_a_valid),
        .dn_a_ready    (dn_a_ready),
        .dn_d_opcode   (dn_d_opcode),
        .dn_d_param    (dn_d_param),
        .dn_d_size     (dn_d_size),
        .dn_d_source   (dn_d_source),
        .dn_d_denied   (dn_d_denied),
        .dn_d_data     (dn_d_data),
        .dn_d_corrupt  (dn_d_corrupt),
        .dn_d_valid    (dn_d_valid),
        .dn_d_ready    (dn_d_ready),
        .proto_err_o   (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data the SRAM model returns for a given address.
    function automatic logic [31:0] rdata(input logic [15:0] addr);
        return {addr ^ 16'hC3A5, addr};
    endfunction

    // Responder: drives ready/response inputs on the falling edge.
    always @(negedge clk) begin
        dn_a_ready = a_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        up_d_ready = d_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() > 0 && (!r_rand || $urandom_range(0, 1) == 1)) begin
            head         = pend[0];
            dn_d_valid   = 1'b1;
            dn_d_opcode  = (head.op == 3'd4) ? 3'd1 : 3'd0;
            dn_d_param   = 2'd0;
            dn_d_size    = head.size;
            dn_d_source  = head.src;
            dn_d_data    = (head.op == 3'd4) ? rdata(head.addr) : 32'd0;
            dn_d_denied  = deny_en && (head.addr == deny_addr);
            dn_d_corrupt = 1'b0;
        end else begin
            dn_d_valid   = 1'b0;
            dn_d_opcode  = 3'd0;
            dn_d_param   = 2'd0;
            dn_d_size    = 4'd0;
            dn_d_source  = 4'd0;
            dn_d_data    = 32'd0;
            dn_d_denied  = 1'b0;
            dn_d_corrupt = 1'b0;
        end
    end

    // Monitor: logs handshakes on the rising edge.
    always @(posedge clk) begin
        a_beat_t b;
        d_beat_t r;
        if (!rst_n) begin
            pend.delete();
        end else begin
            if (dn_d_valid && dn_d_ready && pend.size() > 0) void'(pend.pop_front());
            if (dn_a_valid && dn_a_ready) begin
                b.op = dn_a_opcode; b.size = dn_a_size; b.src = dn_a_source;
                b.addr = dn_a_address; b.mask = dn_a_mask; b.data = dn_a_data;
                pend.push_back(b);
                dn_log.push_back(b);
            end
            if (up_d_valid && up_d_ready) begin
                r.op = up_d_opcode; r.size = up_d_size; r.src = up_d_source;
                r.denied = up_d_denied; r.data = up_d_data;
                up_log.push_back(r);
            end
        end
    end

    task automatic clear_logs();
        dn_log.delete();
        up_log.delete();
    endtask

    // Present one upstream A beat and hold it until accepted (bounded).
    task automatic a_beat(input logic [2:0] op, input logic [3:0] size, input logic [3:0] src,
                          input logic [15:0] addr, input logic [3:0] mask, input logic [31:0] data,
                          output bit ok);
        ok = 1'b0;
        @(negedge clk);
        up_a_opcode = op; up_a_param = 3'd0; up_a_size = size; up_a_source = src;
        up_a_address = addr; up_a_mask = mask; up_a_data = data; up_a_corrupt = 1'b0;
        up_a_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (up_a_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(posedge clk);
        #1;
        up_a_valid = 1'b0;
    endtask

    // Wait (bounded) for n upstream responses, then let stray traffic show up.
    task automatic wait_up(input int n);
        for (int i = 0; i < 400; i++) begin
            if (up_log.size() >= n) break;
            @(posedge clk);
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        up_a_valid = 1'b1; up_a_opcode = 3'd4; up_a_size = 4'd7;
        #1;
        n_cmp++; if (up_a_ready !== 1'b0) begin n_bad++; $display("FAIL reset_up_a_ready: got %b want 0", up_a_ready); end
        n_cmp++; if (dn_a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dn_a_valid: got %b want 0", dn_a_valid); end
        n_cmp++; if (up_d_valid !== 1'b0) begin n_bad++; $display("FAIL reset_up_d_valid: got %b want 0", up_d_valid); end
        n_cmp++; if (dn_d_ready !== 1'b0) begin n_bad++; $display("FAIL reset_dn_d_ready: got %b want 0", dn_d_ready); end
        n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL reset_proto_err: got %b want 0", proto_err_o); end
        up_a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pass_get();
        clear_logs();
        @(negedge clk);
        up_a_opcode = 3'd4; up_a_param = 3'd0; up_a_size = 4'd2; up_a_source = 4'd5;
        up_a_address = 16'h0010; up_a_mask = 4'hF; up_a_data = 32'd0; up_a_valid = 1'b1;
        #1;
        n_cmp++; if (dn_a_valid !== 1'b1 || dn_a_address !== 16'h0010 || dn_a_opcode !== 3'd4 || dn_a_size !== 4'd2)
            begin n_bad++; $display("FAIL pass_zero_latency: valid %b addr %h op %0d size %0d want 1 0010 4 2", dn_a_valid, dn_a_address, dn_a_opcode, dn_a_size); end
        n_cmp++; if (up_a_ready !== 1'b1) begin n_bad++; $display("FAIL pass_up_a_ready: got %b want 1", up_a_ready); end
        @(posedge clk);
        #1;
        up_a_valid = 1'b0;
        wait_up(1);
        n_cmp++; if (dn_log.size() != 1) begin n_bad++; $display("FAIL pass_dn_count: got %0d want 1", dn_log.size()); end
        n_cmp++; if (up_log.size() != 1) begin n_bad++; $display("FAIL pass_up_count: got %0d want 1", up_log.size()); end
        else if (up_log[0].size !== 4'd2 || up_log[0].src !== 4'd5 || up_log[0].op !== 3'd1 || up_log[0].data !== rdata(16'h0010))
            begin n_bad++; $display("FAIL pass_resp: size %0d src %0d op %0d data %h want 2 5 1 %h", up_log[0].size, up_log[0].src, up_log[0].op, up_log[0].data, rdata(16'h0010)); end
    endtask

    task automatic test_get_burst();
        bit ok;
        logic [15:0] ea;
        clear_logs();
        a_rand = 1'b1; d_rand = 1'b1; r_rand = 1'b1;
        a_beat(3'd4, 4'd5, 4'd3, 16'h0100, 4'hF, 32'd0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL get_accept: got 0 want 1"); end
        @(negedge clk);
        up_a_valid = 1'b1; up_a_size = 4'd2;
        #1;
        n_cmp++; if (up_a_ready !== 1'b0) begin n_bad++; $display("FAIL get_issue_blocks_a: got %b want 0", up_a_ready); end
        up_a_valid = 1'b0;
        wait_up(8);
        n_cmp++; if (dn_log.size() != 8) begin n_bad++; $display("FAIL get_dn_count: got %0d want 8", dn_log.size()); end
        for (int k = 0; k < 8; k++) begin
            ea = 16'h0100 + 16'(4 * k);
            n_cmp++;
            if (k >= dn_log.size() || dn_log[k].addr !== ea || dn_log[k].op !== 3'd4 || dn_log[k].size !== 4'd2 || dn_log[k].mask !== 4'hF)
                begin n_bad++; $display("FAIL get_dn_beat%0d: want addr %h Get size 2 mask F", k, ea); end
        end
        n_cmp++; if (up_log.size() != 8) begin n_bad++; $display("FAIL get_up_count: got %0d want 8", up_log.size()); end
        for (int k = 0; k < 8; k++) begin
            ea = 16'h0100 + 16'(4 * k);
            n_cmp++;
            if (k >= up_log.size() || up_log[k].size !== 4'd5 || up_log[k].src !== 4'd3 || up_log[k].op !== 3'd1 || up_log[k].data !== rdata(ea))
                begin n_bad++; $display("FAIL get_up_beat%0d: want size 5 src 3 op 1 data %h", k, rdata(ea)); end
        end
        a_rand = 1'b0; d_rand = 1'b0; r_rand = 1'b0;
    endtask

    task automatic test_put_burst();
        bit ok;
        logic [15:0] ea;
        clear_logs();
        d_rand = 1'b1; r_rand = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_beat(3'd0, 4'd4, 4'd9, 16'h0200, 4'hF, 32'h1111_0000 + 32'(k), ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL put_accept%0d: got 0 want 1", k); end
        end
        wait_up(1);
        n_cmp++; if (dn_log.size() != 4) begin n_bad++; $display("FAIL put_dn_count: got %0d want 4", dn_log.size()); end
        for (int k = 0; k < 4; k++) begin
            ea = 16'h0200 + 16'(4 * k);
            n_cmp++;
            if (k >= dn_log.size() || dn_log[k].addr !== ea || dn_log[k].op !== 3'd0 || dn_log[k].size !== 4'd2 || dn_log[k].data !== 32'h1111_0000 + 32'(k))
                begin n_bad++; $display("FAIL put_dn_beat%0d: want addr %h PutFull size 2 data %h", k, ea, 32'h1111_0000 + 32'(k)); end
        end
        n_cmp++; if (up_log.size() != 1) begin n_bad++; $display("FAIL put_up_count: got %0d want 1", up_log.size()); end
        else if (up_log[0].op !== 3'd0 || up_log[0].size !== 4'd4 || up_log[0].src !== 4'd9 || up_log[0].denied !== 1'b0)
            begin n_bad++; $display("FAIL put_resp: op %0d size %0d src %0d denied %b want 0 4 9 0", up_log[0].op, up_log[0].size, up_log[0].src, up_log[0].denied); end
        d_rand = 1'b0; r_rand = 1'b0;
    endtask

    task automatic test_put_denied();
        bit ok;
        clear_logs();
        deny_en = 1'b1; deny_addr = 16'h0300;
        for (int k = 0; k < 2; k++) begin
            a_beat(3'd0, 4'd3, 4'd6, 16'h0300, 4'hF, 32'(k), ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL deny_accept%0d: got 0 want 1", k); end
        end
        wait_up(1);
        n_cmp++; if (up_log.size() != 1) begin n_bad++; $display("FAIL deny_up_count: got %0d want 1", up_log.size()); end
        else if (up_log[0].denied !== 1'b1 || up_log[0].size !== 4'd3)
            begin n_bad++; $display("FAIL deny_resp: denied %b size %0d want 1 3", up_log[0].denied, up_log[0].size); end
        deny_en = 1'b0;
    endtask

    task automatic test_wrap();
        bit ok;
        logic [15:0] ea;
        clear_logs();
        a_beat(3'd4, 4'd6, 4'd1, 16'hFFC0, 4'hF, 32'd0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_get_accept: got 0 want 1"); end
        wait_up(16);
        n_cmp++; if (dn_log.size() != 16) begin n_bad++; $display("FAIL wrap_get_dn_count: got %0d want 16", dn_log.size()); end
        for (int k = 0; k < 16; k++) begin
            ea = 16'hFFC0 + 16'(4 * k);
            n_cmp++;
            if (k >= up_log.size() || k >= dn_log.size() || dn_log[k].addr !== ea || up_log[k].data !== rdata(ea) || up_log[k].size !== 4'd6)
                begin n_bad++; $display("FAIL wrap_get_beat%0d: want addr %h data %h size 6", k, ea, rdata(ea)); end
        end
        clear_logs();
        for (int k = 0; k < 4; k++) begin
            a_beat(3'd1, 4'd4, 4'd2, 16'hFFF8, 4'h3, 32'hA0 + 32'(k), ok);
            n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_put_accept%0d: got 0 want 1", k); end
        end
        wait_up(1);
        for (int k = 0; k < 4; k++) begin
            ea = 16'hFFF8 + 16'(4 * k);
            n_cmp++;
            if (k >= dn_log.size() || dn_log[k].addr !== ea || dn_log[k].op !== 3'd1 || dn_log[k].mask !== 4'h3)
                begin n_bad++; $display("FAIL wrap_put_beat%0d: want addr %h PutPartial mask 3", k, ea); end
        end
        n_cmp++; if (up_log.size() != 1) begin n_bad++; $display("FAIL wrap_put_up_count: got %0d want 1", up_log.size()); end
    endtask

    task automatic test_reset_mid_burst();
        bit ok;
        clear_logs();
        a_beat(3'd4, 4'd5, 4'd7, 16'h0400, 4'hF, 32'd0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL midrst_accept: got 0 want 1"); end
        for (int i = 0; i < 50 && dn_log.size() < 3; i++) @(negedge clk);
        n_cmp++; if (dn_log.size() != 3) begin n_bad++; $display("FAIL midrst_beats_before: got %0d want 3", dn_log.size()); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (up_a_ready !== 1'b0 || dn_a_valid !== 1'b0 || up_d_valid !== 1'b0 || dn_d_ready !== 1'b0)
            begin n_bad++; $display("FAIL midrst_valids: a_rdy %b dn_a_v %b up_d_v %b dn_d_rdy %b want 0 0 0 0", up_a_ready, dn_a_valid, up_d_valid, dn_d_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (dn_log.size() != 0 || up_log.size() != 0)
            begin n_bad++; $display("FAIL midrst_abandon: dn %0d up %0d want 0 0", dn_log.size(), up_log.size()); end
        a_beat(3'd4, 4'd2, 4'd4, 16'h0020, 4'hF, 32'd0, ok);
        wait_up(1);
        n_cmp++; if (up_log.size() != 1) begin n_bad++; $display("FAIL midrst_next_count: got %0d want 1", up_log.size()); end
        else if (up_log[0].data !== rdata(16'h0020) || up_log[0].src !== 4'd4)
            begin n_bad++; $display("FAIL midrst_next_resp: data %h src %0d want %h 4", up_log[0].data, up_log[0].src, rdata(16'h0020)); end
    endtask

    task automatic test_proto_err();
        bit ok;
        clear_logs();
        n_cmp++; if (proto_err_o !== 1'b0) begin n_bad++; $display("FAIL perr_before: got %b want 0", proto_err_o); end
        a_beat(3'd4, 4'd7, 4'd1, 16'h0500, 4'hF, 32'd0, ok);
        n_cmp++; if (!ok) begin n_bad++; $display("FAIL perr_consume: got 0 want 1"); end
        n_cmp++; if (proto_err_o !== 1'b1) begin n_bad++; $display("FAIL perr_set: got %b want 1", proto_err_o); end
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (dn_log.size() != 0 || up_log.size() != 0)
            begin n_bad++; $display("FAIL perr_silent: dn %0d up %0d want 0 0", dn_log.size(), up_log.size()); end
        a_beat(3'd4, 4'd2, 4'd2, 16'h0030, 4'hF, 32'd0, ok);
        wait_up(1);
        n_cmp++; if (up_log.size() != 1) begin n_bad++; $display("FAIL perr_next_count: got %0d want 1", up_log.size()); end
        else if (up_log[0].data !== rdata(16'h0030) || up_log[0].src !== 4'd2)
            begin n_bad++; $display("FAIL perr_next_resp: data %h src %0d want %h 2", up_log[0].data, up_log[0].src, rdata(16'h0030)); end
        n_cmp++; if (proto_err_o !== 1'b1) begin n_bad++; $display("FAIL perr_sticky: got %b want 1", proto_err_o); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        a_rand = 1'b0; d_rand = 1'b0; r_rand = 1'b0; deny_en = 1'b0; deny_addr = 16'h0000;
        rst_n = 1'b0;
        up_a_opcode = 3'd0; up_a_param = 3'd0; up_a_size = 4'd0; up_a_source = 4'd0;
        up_a_address = 16'd0; up_a_mask = 4'd0; up_a_data = 32'd0; up_a_corrupt = 1'b0; up_a_valid = 1'b0;
        dn_a_ready = 1'b0; up_d_ready = 1'b0;
        dn_d_valid = 1'b0; dn_d_opcode = 3'd0; dn_d_param = 2'd0; dn_d_size = 4'd0;
        dn_d_source = 4'd0; dn_d_denied = 1'b0; dn_d_data = 32'd0; dn_d_corrupt = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_pass_get();
        test_get_burst();
        test_put_burst();
        test_put_denied();
        test_wrap();
        test_reset_mid_burst();
        test_proto_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
